// File: rtl/game_state_pkg.sv
// Shared board geometry and lock-controller types.
//   BOARD_WIDTH / BOARD_HEIGHT : board size, shared with the landing checker
//   lock_state_t               : lock-controller FSM states
//   game_state_t               : fixed board, screen[x][y], y = 0 is the bottom row
//   fixed_game_state_heights_t : per-column stack heights used by the checker
package game_state_pkg;

  localparam int BOARD_WIDTH  = 10;
  localparam int BOARD_HEIGHT = 20;

  typedef enum logic [2:0] {
    LS_SPAWN = 3'd0,
    LS_FALL  = 3'd1,
    LS_MERGE = 3'd2,
    LS_CLEAR = 3'd3,
    LS_DEAD  = 3'd4
  } lock_state_t;

  typedef struct packed {
    logic [BOARD_WIDTH-1:0][BOARD_HEIGHT-1:0] screen;
  } game_state_t;

  typedef struct packed {
    logic [BOARD_WIDTH-1:0][4:0] heights;
  } fixed_game_state_heights_t;

endpackage

// File: rtl/tetris_pkg.sv
// Active-piece description shared by the piece mover, landing checker and
// lock controller.
//   piece[row][col] : 4x4 occupancy, row 0 is the top of the piece
//   x               : board column of piece column 0
//   y               : board row of piece row 0, counted from the top
package tetris_pkg;

  typedef struct packed {
    logic [3:0][3:0] piece;
    logic [4:0]      x;
    logic [4:0]      y;
  } active_piece_grid_t;

endpackage

// File: rtl/piece_merge.sv
// Combinational merge of the active piece into the fixed board.
//   board           : current fixed board
//   piece_grid      : active piece and its position
//   merged          : board with every in-range piece cell ORed in
//   any_cell_at_top : piece sits at y == 0 with at least one cell set
module piece_merge
  import game_state_pkg::*;
  import tetris_pkg::*;
(
  input  game_state_t        board,
  input  active_piece_grid_t piece_grid,
  output game_state_t        merged,
  output logic               any_cell_at_top
);

  localparam int XW = $clog2(BOARD_WIDTH);
  localparam int YW = $clog2(BOARD_HEIGHT);

  logic [5:0] col;
  logic [5:0] row;

  // Positions are widened to 6 bits so x+c / y+r never wrap before the
  // range check; out-of-board cells are simply dropped.
  always_comb begin
    merged = board;
    col    = '0;
    row    = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        col = 6'(piece_grid.x) + 6'(c);
        row = 6'(piece_grid.y) + 6'(r);
        if (piece_grid.piece[r][c] && (col < 6'(BOARD_WIDTH)) && (row < 6'(BOARD_HEIGHT)))
          merged.screen[col[XW-1:0]][YW'(6'(BOARD_HEIGHT - 1) - row)] = 1'b1;
      end
    end
  end

  assign any_cell_at_top = (piece_grid.y == '0) && (|piece_grid.piece);

endmodule

// File: rtl/piece_lock_controller.sv
// Piece lock controller: on each gravity tick decides between dropping the
// active piece one row and locking it; on lock merges the piece into the
// fixed board, clears full rows one per cycle and requests a new piece.
// Optional macro PIECE_LOCK_HARD_DROP_EN adds the hard_drop input.
//   GAME_clk / GAME_reset_n   : clock, asynchronous active-low reset
//   gravity_tick              : one-cycle gravity pulse (acted on in FALL only)
//   no_piece                  : no active piece exists
//   active_piece_grid         : active piece and position
//   active_piece_toutching    : landing-checker verdict
//   hard_drop (optional)      : hard-drop request pulse
//   piece_drop                : one-cycle pulse, move piece down one row
//   spawn_req                 : level request for a new piece
//   GAME_fixed_state          : registered fixed board
//   lines_cleared             : saturating count of cleared rows
//   busy                      : registered, high in MERGE/CLEAR/SPAWN
//   game_over                 : sticky until reset
module piece_lock_controller
  import game_state_pkg::*;
  import tetris_pkg::*;
#(
  parameter int unsigned LOCK_TICKS = 2,
  parameter int unsigned LINES_W    = 16
) (
  input  logic               GAME_clk,
  input  logic               GAME_reset_n,
  input  logic               gravity_tick,
  input  logic               no_piece,
  input  active_piece_grid_t active_piece_grid,
  input  logic               active_piece_toutching,
`ifdef PIECE_LOCK_HARD_DROP_EN
  input  logic               hard_drop,
`endif
  output logic               piece_drop,
  output logic               spawn_req,
  output game_state_t        GAME_fixed_state,
  output logic [LINES_W-1:0] lines_cleared,
  output logic               busy,
  output logic               game_over
);

  localparam int            YW         = $clog2(BOARD_HEIGHT);
  localparam logic [YW-1:0] TOP_ROW    = YW'(BOARD_HEIGHT - 1);
  localparam logic [3:0]    LOCK_LIMIT = 4'(LOCK_TICKS);

  lock_state_t        state, state_nxt;
  logic [3:0]         lock_cnt, lock_cnt_nxt, lock_cnt_inc;
  logic [YW-1:0]      ptr, ptr_nxt;
  game_state_t        board_nxt, merged, shifted;
  logic               any_cell_at_top, row_full;
  logic               drop_nxt, busy_nxt, over_nxt;
  logic [LINES_W-1:0] lines_nxt;
`ifdef PIECE_LOCK_HARD_DROP_EN
  logic               hd_flag, hd_flag_nxt, hd_phase, hd_phase_nxt;
`endif

  function automatic logic [LINES_W-1:0] sat_inc(input logic [LINES_W-1:0] v);
    return (&v) ? v : v + LINES_W'(1);
  endfunction

  piece_merge u_merge (
    .board          (GAME_fixed_state),
    .piece_grid     (active_piece_grid),
    .merged         (merged),
    .any_cell_at_top(any_cell_at_top)
  );

  assign lock_cnt_inc = lock_cnt + 4'd1;
  assign spawn_req    = (state == LS_SPAWN);

  // Row-full detect at ptr and the collapse of everything above it.
  always_comb begin
    row_full = 1'b1;
    shifted  = GAME_fixed_state;
    for (int c = 0; c < BOARD_WIDTH; c++) begin
      row_full = row_full & GAME_fixed_state.screen[c][ptr];
      for (int r = 0; r < BOARD_HEIGHT - 1; r++)
        if (YW'(r) >= ptr) shifted.screen[c][r] = GAME_fixed_state.screen[c][r+1];
      shifted.screen[c][BOARD_HEIGHT-1] = 1'b0;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    ptr_nxt      = ptr;
    board_nxt    = GAME_fixed_state;
    lines_nxt    = lines_cleared;
    over_nxt     = game_over;
    drop_nxt     = 1'b0;
`ifdef PIECE_LOCK_HARD_DROP_EN
    hd_flag_nxt  = hd_flag;
    hd_phase_nxt = 1'b0;
`endif
    case (state)
      LS_SPAWN: begin
        lock_cnt_nxt = '0;
`ifdef PIECE_LOCK_HARD_DROP_EN
        hd_flag_nxt  = 1'b0;
`endif
        if (!no_piece) state_nxt = LS_FALL;
      end
      LS_FALL: begin
`ifdef PIECE_LOCK_HARD_DROP_EN
        hd_flag_nxt = hd_flag | hard_drop;
        // Hard drop: drop on alternate cycles so the landing checker sees
        // each new position before the next move; first touch locks.
        if (hd_flag) begin
          if (active_piece_toutching) begin
            state_nxt = LS_MERGE;
          end else begin
            drop_nxt     = ~hd_phase;
            hd_phase_nxt = ~hd_phase;
          end
        end else
`endif
        if (gravity_tick) begin
          if (no_piece) begin
            state_nxt = LS_SPAWN;
          end else if (!active_piece_toutching) begin
            drop_nxt     = 1'b1;
            lock_cnt_nxt = '0;
          end else if (lock_cnt_inc == LOCK_LIMIT) begin
            state_nxt    = LS_MERGE;
            lock_cnt_nxt = '0;
          end else begin
            lock_cnt_nxt = lock_cnt_inc;
          end
        end
      end
      LS_MERGE: begin
        board_nxt = merged;
        ptr_nxt   = '0;
`ifdef PIECE_LOCK_HARD_DROP_EN
        hd_flag_nxt = 1'b0;
`endif
        if (any_cell_at_top) begin
          over_nxt  = 1'b1;
          state_nxt = LS_DEAD;
        end else begin
          state_nxt = LS_CLEAR;
        end
      end
      LS_CLEAR: begin
        // ptr stays put after a clear: the row shifted into it may be full too.
        if (row_full) begin
          board_nxt = shifted;
          lines_nxt = sat_inc(lines_cleared);
        end else if (ptr == TOP_ROW) begin
          state_nxt = LS_SPAWN;
        end else begin
          ptr_nxt = ptr + YW'(1);
        end
      end
      LS_DEAD: begin
      end
      default: state_nxt = LS_SPAWN;
    endcase
    busy_nxt = (state_nxt == LS_MERGE) || (state_nxt == LS_CLEAR) || (state_nxt == LS_SPAWN);
  end

  always_ff @(posedge GAME_clk or negedge GAME_reset_n) begin
    if (!GAME_reset_n) begin
      state            <= LS_SPAWN;
      lock_cnt         <= '0;
      ptr              <= '0;
      GAME_fixed_state <= '0;
      lines_cleared    <= '0;
      piece_drop       <= 1'b0;
      busy             <= 1'b0;
      game_over        <= 1'b0;
`ifdef PIECE_LOCK_HARD_DROP_EN
      hd_flag          <= 1'b0;
      hd_phase         <= 1'b0;
`endif
    end else begin
      state            <= state_nxt;
      lock_cnt         <= lock_cnt_nxt;
      ptr              <= ptr_nxt;
      GAME_fixed_state <= board_nxt;
      lines_cleared    <= lines_nxt;
      piece_drop       <= drop_nxt;
      busy             <= busy_nxt;
      game_over        <= over_nxt;
`ifdef PIECE_LOCK_HARD_DROP_EN
      hd_flag          <= hd_flag_nxt;
      hd_phase         <= hd_phase_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_piece_lock_controller.sv
// Self-checking bench for piece_lock_controller: a table of single-piece
// lock vectors with hand-computed boards, plus hand-written sequences for
// spawn handshake, drops, lock counting, row clearing, game over and reset.
module tb_piece_lock_controller;
  import game_state_pkg::*;
  import tetris_pkg::*;

  logic               GAME_clk = 1'b0;
  logic               GAME_reset_n;
  logic               gravity_tick;
  logic               no_piece;
  active_piece_grid_t active_piece_grid;
  logic               active_piece_toutching;
  logic               piece_drop;
  logic               spawn_req;
  game_state_t        GAME_fixed_state;
  logic [15:0]        lines_cleared;
  logic               busy;
  logic               game_over;
`ifdef PIECE_LOCK_HARD_DROP_EN
  logic               hard_drop = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int drop_cnt = 0;

  always #5 GAME_clk = ~GAME_clk;

  always @(posedge GAME_clk) if (piece_drop === 1'b1) drop_cnt <= drop_cnt + 1;

  piece_lock_controller #(.LOCK_TICKS(2), .LINES_W(16)) dut (
    .GAME_clk              (GAME_clk),
    .GAME_reset_n          (GAME_reset_n),
    .gravity_tick          (gravity_tick),
    .no_piece              (no_piece),
    .active_piece_grid     (active_piece_grid),
    .active_piece_toutching(active_piece_toutching),
`ifdef PIECE_LOCK_HARD_DROP_EN
    .hard_drop             (hard_drop),
`endif
    .piece_drop            (piece_drop),
    .spawn_req             (spawn_req),
    .GAME_fixed_state      (GAME_fixed_state),
    .lines_cleared         (lines_cleared),
    .busy                  (busy),
    .game_over             (game_over)
  );

  typedef struct {
    string           name;
    logic [15:0]     piece;  // nibble r = piece row r, bit c = column c
    logic [4:0]      x;
    logic [4:0]      y;
    logic [4:0]      yb;     // screen row of m[0]
    logic [3:0][9:0] m;      // column masks for screen rows yb..yb+3
    bit              chk_board;
    bit              exp_over;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_board(input string name, input game_state_t act, input game_state_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic game_state_t board_of(input vec_t v);
    game_state_t b = '0;
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < BOARD_WIDTH; c++)
        if (int'(v.yb) + i < BOARD_HEIGHT && v.m[i][c])
          b.screen[4'(c)][5'(int'(v.yb) + i)] = 1'b1;
    return b;
  endfunction

  function automatic active_piece_grid_t grid(input logic [15:0] p, input int x, input int y);
    active_piece_grid_t g;
    g.piece = p;
    g.x     = 5'(x);
    g.y     = 5'(y);
    return g;
  endfunction

  task automatic setv(input int i, input string n, input logic [15:0] p, input int x, input int y,
                      input int yb, input logic [9:0] m3, input logic [9:0] m2,
                      input logic [9:0] m1, input logic [9:0] m0, input bit chk, input bit ov);
    vecs[i].name = n;  vecs[i].piece = p;  vecs[i].x = 5'(x);  vecs[i].y = 5'(y);
    vecs[i].yb = 5'(yb);  vecs[i].m = {m3, m2, m1, m0};
    vecs[i].chk_board = chk;  vecs[i].exp_over = ov;
  endtask

  task automatic step();
    @(posedge GAME_clk);
    #1;
  endtask

  task automatic grav();
    gravity_tick = 1'b1;
    step();
    gravity_tick = 1'b0;
  endtask

  task automatic do_reset();
    gravity_tick = 1'b0;
    no_piece = 1'b1;
    active_piece_toutching = 1'b0;
    active_piece_grid = '0;
    GAME_reset_n = 1'b0;
    step();
    step();
    GAME_reset_n = 1'b1;
  endtask

  // Precondition: controller in SPAWN. Ends on the edge that enters MERGE.
  task automatic lock_start(input active_piece_grid_t g);
    active_piece_grid = g;
    no_piece = 1'b0;
    active_piece_toutching = 1'b1;
    step();
    grav();
    step();
    grav();
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    while (!(spawn_req || game_over) && cyc < 60) begin
      step();
      cyc++;
    end
    check({name, "_done"}, 32'(spawn_req || game_over), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int cyc;
    int d0;
    game_state_t exp_b;

    setv(0, "i_flat_bottom",  16'h000F, 4, 19, 0,  10'h0,   10'h0,   10'h0,   10'h0F0, 1, 0);
    setv(1, "o_two_rows",     16'h0033, 0, 18, 0,  10'h0,   10'h0,   10'h003, 10'h003, 1, 0);
    setv(2, "i_clip_right",   16'h000F, 8, 19, 0,  10'h0,   10'h0,   10'h0,   10'h300, 1, 0);
    setv(3, "o_clip_bottom",  16'h0033, 3, 19, 0,  10'h0,   10'h0,   10'h0,   10'h018, 1, 0);
    setv(4, "i_vertical",     16'h2222, 8, 10, 6,  10'h200, 10'h200, 10'h200, 10'h200, 1, 0);
    setv(5, "t_high",         16'h0027, 2, 5,  13, 10'h0,   10'h0,   10'h01C, 10'h008, 1, 0);
    setv(6, "o_clip_corner",  16'h0033, 9, 19, 0,  10'h0,   10'h0,   10'h0,   10'h200, 1, 0);
    setv(7, "o_top_over",     16'h0033, 0, 0,  16, 10'h0,   10'h0,   10'h0,   10'h0,   0, 1);

    // Reset values and spawn handshake
    gravity_tick = 1'b0;  no_piece = 1'b1;  active_piece_toutching = 1'b0;
    active_piece_grid = '0;
    GAME_reset_n = 1'b0;
    step();
    check_board("rst_board", GAME_fixed_state, '0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_drop", 32'(piece_drop), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_spawn", 32'(spawn_req), 32'd1);
    GAME_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("spawn_hold", 32'(spawn_req), 32'd1);
    end
    check("spawn_busy", 32'(busy), 32'd1);
    no_piece = 1'b0;
    step();
    check("spawn_release", 32'(spawn_req), 32'd0);
    check("fall_busy", 32'(busy), 32'd0);

    // Five non-touching ticks: one drop each, one cycle after the tick
    active_piece_grid = grid(16'h0033, 4, 18);
    d0 = drop_cnt;
    for (int k = 0; k < 5; k++) begin
      grav();
      check("drop_pulse", 32'(piece_drop), 32'd1);
      step();
      check("drop_end", 32'(piece_drop), 32'd0);
      step();
    end
    check("drop_count", 32'(drop_cnt - d0), 32'd5);
    check_board("drop_board", GAME_fixed_state, '0);

    // Lock counter: non-touching tick clears it; deassert between ticks does not
    active_piece_toutching = 1'b1;
    grav();
    check("cnt1_nodrop", 32'(piece_drop), 32'd0);
    check("cnt1_nolock", 32'(busy), 32'd0);
    active_piece_toutching = 1'b0;
    grav();
    check("cnt_clr_drop", 32'(piece_drop), 32'd1);
    active_piece_toutching = 1'b1;
    grav();
    check("cnt_restart", 32'(busy), 32'd0);
    active_piece_toutching = 1'b0;
    step();
    step();
    active_piece_toutching = 1'b1;
    grav();
    check("cnt_lock", 32'(busy), 32'd1);
    check("cnt_lock_nodrop", 32'(piece_drop), 32'd0);
    wait_done("cnt", cyc);
    exp_b = '0;
    exp_b.screen[4][0] = 1'b1;  exp_b.screen[5][0] = 1'b1;
    exp_b.screen[4][1] = 1'b1;  exp_b.screen[5][1] = 1'b1;
    check_board("cnt_board", GAME_fixed_state, exp_b);

    // Single-piece lock table on an empty board
    for (int i = 0; i < 8; i++) begin
      do_reset();
      lock_start(grid(vecs[i].piece, int'(vecs[i].x), int'(vecs[i].y)));
      wait_done(vecs[i].name, cyc);
      if (vecs[i].chk_board)
        check_board({vecs[i].name, "_board"}, GAME_fixed_state, board_of(vecs[i]));
      check({vecs[i].name, "_over"}, 32'(game_over), 32'(vecs[i].exp_over));
      check({vecs[i].name, "_lines"}, 32'(lines_cleared), 32'd0);
      if (i == 0) check("empty_clear_cycles", 32'(cyc), 32'd21);
    end

    // Game over: frozen outputs, then reset clears the flag
    check("dead_busy", 32'(busy), 32'd0);
    active_piece_toutching = 1'b0;
    no_piece = 1'b0;
    for (int k = 0; k < 3; k++) begin
      grav();
      check("dead_drop", 32'(piece_drop), 32'd0);
      check("dead_spawn", 32'(spawn_req), 32'd0);
    end
    check("dead_sticky", 32'(game_over), 32'd1);
    do_reset();
    check("dead_reset", 32'(game_over), 32'd0);

    // Row clear: row 0 completes, row 1 cell at x=9 falls into row 0
    lock_start(grid(16'h000F, 4, 19));
    wait_done("pre_a", cyc);
    lock_start(grid(16'h0032, 8, 18));
    wait_done("pre_b", cyc);
    lock_start(grid(16'h000F, 0, 19));
    wait_done("clr", cyc);
    exp_b = '0;
    exp_b.screen[9][0] = 1'b1;
    check_board("clr_board", GAME_fixed_state, exp_b);
    check("clr_lines", 32'(lines_cleared), 32'd1);
    check("clr_cycles", 32'(cyc), 32'd22);

    // Reset in the middle of clearing two full rows
    do_reset();
    for (int k = 0; k < 4; k++) begin
      lock_start(grid(16'h0033, 2 * k, 18));
      wait_done("fill", cyc);
    end
    lock_start(grid(16'h0033, 8, 18));
    step();
    step();
    check("mid_clear_lines", 32'(lines_cleared), 32'd1);
    GAME_reset_n = 1'b0;
    #1;
    check_board("async_board", GAME_fixed_state, '0);
    check("async_lines", 32'(lines_cleared), 32'd0);
    step();
    no_piece = 1'b1;
    GAME_reset_n = 1'b1;
    step();
    check("post_rst_spawn", 32'(spawn_req), 32'd1);
    check_board("post_rst_board", GAME_fixed_state, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
